elixirchip_es1_spu_flag_gen: RTL and testbench
==============================================

ELIXIRCHIP_ES1_SPU_FLAG_GEN -- requirements
Module: elixirchip_es1_spu_flag_gen

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: width of one result word from the upstream add op.
REQ-002 SHALL have parameter MAX_WORDS, default 4: maximum words per multi-word operation, legal range 1..16.
REQ-003 SHALL have parameter DEVICE, default "RTL", and parameters SIMULATION and DEBUG, default "false"; all three are pass-through only.
REQ-004 SHALL have these ports, each as name, direction, width, meaning:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- cke  in  1  clock enable.
- s_data  in  DATA_BITS  add-op m_data word.
- s_carry  in  1  add-op m_carry.
- s_msb_c  in  1  add-op m_msb_c.
- s_first  in  1  first word of operation.
- s_last  in  1  last word of operation.
- s_clear  in  1  synchronous clear.
- s_valid  in  1  word valid.
- m_flags  out  4  {N,Z,V,C}.
- m_words  out  $clog2(MAX_WORDS+1)  word count of the completed operation.
- m_error  out  1  protocol error on this result.
- m_valid  out  1  result valid.

Function
REQ-005 All registers SHALL update only when cke=1; when cke=0, state and outputs SHALL hold.
REQ-006 The FSM SHALL have two states: IDLE and ACC.
REQ-007 In IDLE, a word with s_valid&s_first&!s_last SHALL load the accumulator and set count=1, then go to ACC.
REQ-008 In IDLE, a word with s_valid&s_first&s_last SHALL complete a 1-word operation and stay in IDLE.
REQ-009 In IDLE, a word with s_valid&!s_first SHALL be discarded with no output.
REQ-010 In ACC, a word with s_valid&!s_last&!s_first SHALL increment count, AND its zero-detect into Z, and stay in ACC.
REQ-011 In ACC, a word with s_valid&s_last SHALL complete the operation and go to IDLE.
REQ-012 In ACC, a word with s_valid&s_first SHALL abort the current operation and restart accumulation with this word; see REQ-019.
REQ-013 Completion SHALL set the flags as follows:
- C = s_carry of the last word.
- V = s_carry ^ s_msb_c of the last word.
- N = s_data[DATA_BITS-1] of the last word.
- Z = 1 only if every word of the operation is zero.
REQ-014 Latency SHALL be 1 cke-enabled cycle from the completing word to m_valid=1; m_valid SHALL be a single enabled-cycle pulse.
REQ-015 When a word would make count exceed MAX_WORDS-1 without s_last, that word SHALL be treated as the last word (forced completion), and the FSM SHALL go to IDLE.
REQ-016 m_flags, m_words and m_error SHALL hold the last completed result until the next completion.
REQ-017 s_clear=1 with cke=1 SHALL force IDLE, drop the partial operation, and zero count, m_flags, m_words, m_valid and m_error. s_clear SHALL override s_valid in the same cycle.

Reset
REQ-018 reset_n=0 SHALL immediately, independent of clk and cke, force IDLE and drive m_flags=0, m_words=0, m_error=0 and m_valid=0; a partial operation in progress SHALL be lost.

Configuration
REQ-019 Macro ELIXIRCHIP_ES1_SPU_FLAG_GEN_PROTOCOL_CHECK_EN SHALL control protocol checking.
- Defined, on s_first in ACC: the aborted operation SHALL be emitted with m_valid=1, m_error=1, and its partial flags and count.
- Defined, on forced completion (REQ-015): the result SHALL have m_error=1.
- Undefined: the abort SHALL be silent; forced completion SHALL have m_error=0; m_error SHALL be constant 0.

Structure
REQ-020 Package elixirchip_es1_spu_pkg SHALL hold the flags_t packed struct {n,z,v,c} and the state enum {IDLE,ACC}.
REQ-021 Sub-module elixirchip_es1_spu_flag_check SHALL hold the REQ-019 error detection and be instantiated only when the macro is defined.

Verification (DATA_BITS=8, MAX_WORDS=4)
REQ-022 1-word: s_data=0x80, carry=0, msb_c=1, first&last -> next cycle m_valid=1, m_flags N1 Z0 V1 C0, m_words=1.
REQ-023 2-word: 0x00 (carry=1), then 0x00 (carry=1, msb_c=1, last) -> Z1 C1 V0 N0, m_words=2, one m_valid pulse.
REQ-024 cke=0 for 3 cycles between words 1 and 2 of REQ-023 -> identical result, with no m_valid pulse while cke=0.
REQ-025 5 words without s_last:
- Word 4 SHALL force completion with m_words=4.
- m_error SHALL be 1 with the macro defined and 0 without it.
- Word 5 (no s_first) SHALL be discarded.
REQ-026 reset_n=0 mid-ACC -> all outputs 0 with no clk edge; after release, a fresh 1-word operation SHALL complete normally.
REQ-027 s_first during ACC with the macro defined -> error pulse carrying m_words=1, followed by the correct result of the restarted operation.

Source files
------------

// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared types for the ES1 SPU flag generator: result flag layout and FSM states.
package elixirchip_es1_spu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

endpackage

// File: rtl/elixirchip_es1_spu_flag_gen_if.sv
// Word-stream bundle between an add-op source and the flag generator.
interface elixirchip_es1_spu_flag_gen_if #(
  parameter int DATA_BITS = 8,
  parameter int MAX_WORDS = 4
);
  logic                             cke;
  logic [DATA_BITS-1:0]             s_data;
  logic                             s_carry;
  logic                             s_msb_c;
  logic                             s_first;
  logic                             s_last;
  logic                             s_clear;
  logic                             s_valid;
  logic [3:0]                       m_flags;
  logic [$clog2(MAX_WORDS+1)-1:0]   m_words;
  logic                             m_error;
  logic                             m_valid;

  modport master (
    output cke, s_data, s_carry, s_msb_c, s_first, s_last, s_clear, s_valid,
    input  m_flags, m_words, m_error, m_valid
  );

  modport slave (
    input  cke, s_data, s_carry, s_msb_c, s_first, s_last, s_clear, s_valid,
    output m_flags, m_words, m_error, m_valid
  );
endinterface

// File: rtl/elixirchip_es1_spu_flag_check.sv
// Protocol error detection: s_first arriving mid-operation, and word-limit forced completion.
module elixirchip_es1_spu_flag_check
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int MAX_WORDS = 4,
  parameter int CNT_W     = 3
) (
  input  state_t             state,
  input  logic [CNT_W-1:0]   count,
  input  logic               s_valid,
  input  logic               s_first,
  input  logic               s_last,
  output logic               abort_err,
  output logic               force_err
);
  localparam logic [CNT_W-1:0] LIMIT        = CNT_W'(MAX_WORDS - 1);
  localparam bit               FIRST_FORCED = (MAX_WORDS == 1);

  logic limit_hit;

  always_comb begin
    limit_hit = s_first ? FIRST_FORCED : ((state == ACC) && (count == LIMIT));
    abort_err = s_valid & s_first & (state == ACC);
    force_err = s_valid & ~s_last & limit_hit;
  end
endmodule

// File: rtl/elixirchip_es1_spu_flag_gen.sv
// Multi-word N/Z/V/C flag generator for the ES1 SPU add op.
// Optional protocol checking: define ELIXIRCHIP_ES1_SPU_FLAG_GEN_PROTOCOL_CHECK_EN.
module elixirchip_es1_spu_flag_gen
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int MAX_WORDS  = 4,
  parameter     DEVICE     = "RTL",
  parameter     SIMULATION = "false",
  parameter     DEBUG      = "false"
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             cke,
  input  logic [DATA_BITS-1:0]             s_data,
  input  logic                             s_carry,
  input  logic                             s_msb_c,
  input  logic                             s_first,
  input  logic                             s_last,
  input  logic                             s_clear,
  input  logic                             s_valid,
  output logic [3:0]                       m_flags,
  output logic [$clog2(MAX_WORDS+1)-1:0]   m_words,
  output logic                             m_error,
  output logic                             m_valid
);
  localparam int               CNT_W        = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] LIMIT        = CNT_W'(MAX_WORDS - 1);
  localparam bit               FIRST_FORCED = (MAX_WORDS == 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  flags_t           part;

  logic             zero_word;
  flags_t           in_flags;
  logic             in_acc;
  logic             take_first;
  logic             complete_first;
  logic             complete_acc;
  logic             aborting;
  logic             abort_emit;
  logic             emit;
  flags_t           emit_flags;
  logic [CNT_W-1:0] emit_words;

  always_comb begin
    zero_word      = (s_data == '0);
    in_flags       = '{n: s_data[DATA_BITS-1], z: zero_word, v: s_carry ^ s_msb_c, c: s_carry};
    in_acc         = (state == ACC);
    take_first     = s_valid & s_first;
    // s_first always starts a new operation, even in ACC; the old one is abandoned.
    complete_first = take_first & (s_last | FIRST_FORCED);
    complete_acc   = s_valid & ~s_first & in_acc & (s_last | (count == LIMIT));
    aborting       = take_first & in_acc;
    emit           = ~s_clear & (complete_first | complete_acc | (aborting & abort_emit));

    emit_flags = in_flags;
    emit_words = CNT_W'(1);
    if (complete_acc) begin
      emit_flags.z = part.z & zero_word;
      emit_words   = count + 1'b1;
    end else if (!complete_first) begin
      emit_flags = part;
      emit_words = count;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      part    <= '0;
      m_flags <= '0;
      m_words <= '0;
      m_valid <= 1'b0;
    end else if (cke) begin
      m_valid <= emit;
      if (s_clear) begin
        state   <= IDLE;
        count   <= '0;
        part    <= '0;
        m_flags <= '0;
        m_words <= '0;
      end else begin
        if (emit) begin
          m_flags <= emit_flags;
          m_words <= emit_words;
        end
        if (take_first && !complete_first) begin
          state <= ACC;
          count <= CNT_W'(1);
          part  <= in_flags;
        end else if (complete_first || complete_acc) begin
          state <= IDLE;
          count <= '0;
        end else if (s_valid && in_acc) begin
          count <= count + 1'b1;
          part  <= '{n: in_flags.n, z: part.z & zero_word, v: in_flags.v, c: in_flags.c};
        end
      end
    end
  end

`ifdef ELIXIRCHIP_ES1_SPU_FLAG_GEN_PROTOCOL_CHECK_EN
  logic abort_err;
  logic force_err;
  logic err_q;

  elixirchip_es1_spu_flag_check #(
    .MAX_WORDS (MAX_WORDS),
    .CNT_W     (CNT_W)
  ) u_check (
    .state     (state),
    .count     (count),
    .s_valid   (s_valid),
    .s_first   (s_first),
    .s_last    (s_last),
    .abort_err (abort_err),
    .force_err (force_err)
  );

  assign abort_emit = abort_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (cke) begin
      if (s_clear) begin
        err_q <= 1'b0;
      end else if (emit) begin
        err_q <= abort_err | force_err;
      end
    end
  end

  assign m_error = err_q;
`else
  assign abort_emit = 1'b0;
  assign m_error    = 1'b0;
`endif

endmodule

// File: tb/tb_elixirchip_es1_spu_flag_gen.sv
// Directed self-checking bench for elixirchip_es1_spu_flag_gen (DATA_BITS=8, MAX_WORDS=4).
module tb_elixirchip_es1_spu_flag_gen;
  import elixirchip_es1_spu_pkg::*;

`ifdef ELIXIRCHIP_ES1_SPU_FLAG_GEN_PROTOCOL_CHECK_EN
  localparam logic PCHK = 1'b1;
`else
  localparam logic PCHK = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  elixirchip_es1_spu_flag_gen_if #(.DATA_BITS(8), .MAX_WORDS(4)) bus ();

  elixirchip_es1_spu_flag_gen #(
    .DATA_BITS  (8),
    .MAX_WORDS  (4),
    .DEVICE     ("RTL"),
    .SIMULATION ("false"),
    .DEBUG      ("false")
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cke     (bus.cke),
    .s_data  (bus.s_data),
    .s_carry (bus.s_carry),
    .s_msb_c (bus.s_msb_c),
    .s_first (bus.s_first),
    .s_last  (bus.s_last),
    .s_clear (bus.s_clear),
    .s_valid (bus.s_valid),
    .m_flags (bus.m_flags),
    .m_words (bus.m_words),
    .m_error (bus.m_error),
    .m_valid (bus.m_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic valid, input logic [3:0] flags,
                           input logic [2:0] words, input logic err);
    check({tag, ".valid"}, 16'(bus.m_valid), 16'(valid));
    check({tag, ".flags"}, 16'(bus.m_flags), 16'(flags));
    check({tag, ".words"}, 16'(bus.m_words), 16'(words));
    check({tag, ".error"}, 16'(bus.m_error), 16'(err));
  endtask

  // Present one word for one clock, then sample 1 time unit after the edge.
  task automatic drive_word(input logic [7:0] d, input logic carry, input logic msb_c,
                            input logic first, input logic last);
    bus.s_data  = d;
    bus.s_carry = carry;
    bus.s_msb_c = msb_c;
    bus.s_first = first;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_first = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n     = 1'b0;
    bus.cke     = 1'b1;
    bus.s_data  = '0;
    bus.s_carry = 1'b0;
    bus.s_msb_c = 1'b0;
    bus.s_first = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_clear = 1'b0;
    bus.s_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 4'b0000, 3'd0, 1'b0);
    reset_n = 1'b1;
    idle_cycle();

    // 1-word op: 0x80, carry 0, msb_c 1 -> N1 Z0 V1 C0
    drive_word(8'h80, 1'b0, 1'b1, 1'b1, 1'b1);
    check_out("one_word", 1'b1, 4'b1010, 3'd1, 1'b0);
    idle_cycle();
    check_out("one_word_hold", 1'b0, 4'b1010, 3'd1, 1'b0);

    // 2-word op with cke low for 3 cycles while word 2 is presented
    drive_word(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    check("cke_w1.valid", 16'(bus.m_valid), 16'd0);
    bus.cke     = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_carry = 1'b1;
    bus.s_msb_c = 1'b1;
    bus.s_last  = 1'b1;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_out("cke_low", 1'b0, 4'b1010, 3'd1, 1'b0);
    end
    bus.cke = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    check_out("cke_two_word", 1'b1, 4'b0101, 3'd2, 1'b0);
    idle_cycle();
    check("cke_pulse_end", 16'(bus.m_valid), 16'd0);

    // Plain 2-word op, after a distinct result so the flags change is visible
    drive_word(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    check_out("neg_word", 1'b1, 4'b1000, 3'd1, 1'b0);
    drive_word(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    check("two_w1.valid", 16'(bus.m_valid), 16'd0);
    drive_word(8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    check_out("two_word", 1'b1, 4'b0101, 3'd2, 1'b0);
    idle_cycle();
    check("two_pulse_end", 16'(bus.m_valid), 16'd0);

    // 5 words without s_last: word 4 forces completion, word 5 is discarded
    drive_word(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("force_w1.valid", 16'(bus.m_valid), 16'd0);
    drive_word(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("force_w2.valid", 16'(bus.m_valid), 16'd0);
    drive_word(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("force_w3.valid", 16'(bus.m_valid), 16'd0);
    drive_word(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("force_w4", 1'b1, 4'b1011, 3'd4, PCHK);
    drive_word(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("force_w5", 1'b0, 4'b1011, 3'd4, PCHK);

    // s_clear drops a partial op and overrides s_valid in the same cycle
    drive_word(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.s_clear = 1'b1;
    drive_word(8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.s_clear = 1'b0;
    check_out("clear", 1'b0, 4'b0000, 3'd0, 1'b0);
    drive_word(8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    check_out("clear_discard", 1'b0, 4'b0000, 3'd0, 1'b0);

    // Asynchronous reset mid-ACC, then a fresh 1-word op
    drive_word(8'h80, 1'b0, 1'b1, 1'b1, 1'b1);
    check_out("pre_reset", 1'b1, 4'b1010, 3'd1, 1'b0);
    drive_word(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 4'b0000, 3'd0, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive_word(8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    check("post_reset_discard.valid", 16'(bus.m_valid), 16'd0);
    drive_word(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    check_out("post_reset", 1'b1, 4'b0100, 3'd1, 1'b0);

    // s_first during ACC: abort, restart, complete
    drive_word(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    drive_word(8'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
    if (PCHK) begin
      check_out("abort", 1'b1, 4'b0111, 3'd1, 1'b1);
    end else begin
      check_out("abort", 1'b0, 4'b0100, 3'd1, 1'b0);
    end
    drive_word(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    check_out("restart", 1'b1, 4'b0010, 3'd2, 1'b0);
    idle_cycle();
    check("restart_pulse_end", 16'(bus.m_valid), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
